// File: rtl/alu_pkg.sv
// Shared widths, ALU opcodes, driver FSM states and response entry layout
// for the ALU command driver.
`timescale 1ns/1ps
package alu_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int TAG_W  = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'd0;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd1;
    localparam logic [OP_W-1:0] ALU_ADD = 4'd2;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } drv_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic              zero;
        logic [TAG_W-1:0]  tag;
    } rsp_entry_t;
endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO holding tagged ALU results; the head entry is
// presented straight from the storage registers.
`timescale 1ns/1ps
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   push,
    input  rsp_entry_t             push_data,
    input  logic                   pop,
    output rsp_entry_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    rsp_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_driver.sv
// Drives one command at a time into the combinational ALU and queues tagged
// results in order. Optional zero-flag checker/pop counter: ALU_CMD_CHECK_EN.
`timescale 1ns/1ps
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 0
)
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Cmd_valid,
    output logic              Cmd_ready,
    input  logic [DATA_W-1:0] Cmd_A,
    input  logic [DATA_W-1:0] Cmd_B,
    input  logic [OP_W-1:0]   Cmd_Op,
    input  logic [TAG_W-1:0]  Cmd_tag,
    output logic [DATA_W-1:0] Alu_A,
    output logic [DATA_W-1:0] Alu_B,
    output logic [OP_W-1:0]   Alu_Op,
    input  logic [DATA_W-1:0] Alu_Out,
    input  logic              Alu_Zero,
    output logic              Rsp_valid,
    input  logic              Rsp_ready,
    output logic [DATA_W-1:0] Rsp_Out,
    output logic              Rsp_Zero,
    output logic [TAG_W-1:0]  Rsp_tag,
    output logic              Busy
`ifdef ALU_CMD_CHECK_EN
    ,
    output logic              Err_zero,
    output logic [15:0]       Rsp_cnt
`endif
);
    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((ALU_LAT > 0) ? (ALU_LAT - 1) : 0);

    drv_state_t                   state;
    drv_state_t                   state_nxt;
    logic [CNT_W-1:0]             wait_cnt;
    logic [TAG_W-1:0]             tag_q;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(RSP_DEPTH):0]   fifo_count;
    rsp_entry_t                   push_data;
    rsp_entry_t                   head;

    // Gated by Rst_n so the handshake drops the moment reset asserts.
    assign Cmd_ready = Rst_n && (state == IDLE) && !fifo_full;
    assign accept    = Cmd_valid && Cmd_ready;
    assign push      = (state == CAPTURE);
    assign pop       = Rsp_valid && Rsp_ready;
    assign Rsp_valid = !fifo_empty;
    assign Busy      = (state != IDLE) || (fifo_count != '0);
    assign push_data = '{out: Alu_Out, zero: Alu_Zero, tag: tag_q};
    assign Rsp_Out   = head.out;
    assign Rsp_Zero  = head.zero;
    assign Rsp_tag   = head.tag;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   state_nxt = (ALU_LAT == 0) ? CAPTURE : WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands only move on accept, so the ALU sees stable inputs until the next command.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Alu_A    <= '0;
            Alu_B    <= '0;
            Alu_Op   <= '0;
            tag_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                Alu_A  <= Cmd_A;
                Alu_B  <= Cmd_B;
                Alu_Op <= Cmd_Op;
                tag_q  <= Cmd_tag;
            end
            if (state == DRIVE) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    alu_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef ALU_CMD_CHECK_EN
    // Sticky flag for an ALU whose Zero output disagrees with its result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Err_zero <= 1'b0;
            Rsp_cnt  <= '0;
        end else begin
            if ((state == CAPTURE) && (Alu_Zero != (Alu_Out == '0))) begin
                Err_zero <= 1'b1;
            end
            if (pop && (Rsp_cnt != 16'hFFFF)) begin
                Rsp_cnt <= Rsp_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a zero-latency instance and an
// ALU_LAT=2 instance, each driving a behavioural ALU. Covers ALU_CMD_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Cmd_valid;
    logic        l2_valid;
    logic [31:0] Cmd_A;
    logic [31:0] Cmd_B;
    logic [3:0]  Cmd_Op;
    logic [3:0]  Cmd_tag;
    logic        zero_bad;

    logic        Cmd_ready;
    logic [31:0] Alu_A, Alu_B, Alu_Out, Rsp_Out;
    logic [3:0]  Alu_Op, Rsp_tag;
    logic        Alu_Zero, Rsp_valid, Rsp_ready, Rsp_Zero, Busy;

    logic        l2_cmd_ready;
    logic [31:0] l2_alu_a, l2_alu_b, l2_alu_out, l2_rsp_out;
    logic [3:0]  l2_alu_op, l2_rsp_tag;
    logic        l2_alu_zero, l2_rsp_valid, l2_rsp_ready, l2_rsp_zero, l2_busy;
`ifdef ALU_CMD_CHECK_EN
    logic        Err_zero, l2_err_zero;
    logic [15:0] Rsp_cnt, l2_rsp_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    rsp_entry_t rq[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        Alu_Out  = alu_f(Alu_A, Alu_B, Alu_Op);
        Alu_Zero = zero_bad | (Alu_Out == 32'd0);
    end

    always_comb begin
        l2_alu_out  = alu_f(l2_alu_a, l2_alu_b, l2_alu_op);
        l2_alu_zero = (l2_alu_out == 32'd0);
    end

    always @(negedge Clk) begin
        if (Rsp_valid && Rsp_ready) rq.push_back('{out: Rsp_Out, zero: Rsp_Zero, tag: Rsp_tag});
    end

    alu_cmd_driver #(.RSP_DEPTH(4), .ALU_LAT(0)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
        .Cmd_A(Cmd_A), .Cmd_B(Cmd_B), .Cmd_Op(Cmd_Op), .Cmd_tag(Cmd_tag),
        .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Op(Alu_Op), .Alu_Out(Alu_Out), .Alu_Zero(Alu_Zero),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Rsp_Out(Rsp_Out), .Rsp_Zero(Rsp_Zero),
        .Rsp_tag(Rsp_tag), .Busy(Busy)
`ifdef ALU_CMD_CHECK_EN
        , .Err_zero(Err_zero), .Rsp_cnt(Rsp_cnt)
`endif
    );

    alu_cmd_driver #(.RSP_DEPTH(4), .ALU_LAT(2)) u_dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Cmd_valid(l2_valid), .Cmd_ready(l2_cmd_ready),
        .Cmd_A(Cmd_A), .Cmd_B(Cmd_B), .Cmd_Op(Cmd_Op), .Cmd_tag(Cmd_tag),
        .Alu_A(l2_alu_a), .Alu_B(l2_alu_b), .Alu_Op(l2_alu_op), .Alu_Out(l2_alu_out),
        .Alu_Zero(l2_alu_zero), .Rsp_valid(l2_rsp_valid), .Rsp_ready(l2_rsp_ready),
        .Rsp_Out(l2_rsp_out), .Rsp_Zero(l2_rsp_zero), .Rsp_tag(l2_rsp_tag), .Busy(l2_busy)
`ifdef ALU_CMD_CHECK_EN
        , .Err_zero(l2_err_zero), .Rsp_cnt(l2_rsp_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Offers a command to instance 0 (sel=0) or the ALU_LAT=2 instance (sel=1).
    // On timeout valid is left asserted.
    task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [3:0] tg, input int bound,
                        output bit ok);
        Cmd_A = a; Cmd_B = b; Cmd_Op = op; Cmd_tag = tg; ok = 1'b0;
        if (sel) l2_valid = 1'b1; else Cmd_valid = 1'b1;
        for (int k = 0; k < bound; k++) begin
            if ((sel ? l2_cmd_ready : Cmd_ready) == 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            if (sel) l2_valid = 1'b0; else Cmd_valid = 1'b0;
        end
    endtask

    // Exact-latency run on the ALU_LAT=2 instance: result visible after edge t+4.
    task automatic l2_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [3:0] tg, input logic [31:0] exp_out, input string nm);
        Cmd_A = a; Cmd_B = b; Cmd_Op = op; Cmd_tag = tg;
        l2_valid = 1'b1;
        chk({nm, "_ready"}, l2_cmd_ready, 1);
        tick();
        l2_valid = 1'b0;
        Cmd_A = 32'hDEAD_BEEF; Cmd_B = 32'h1234_5678; Cmd_Op = ALU_OR;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_hold_a_%0d", nm, k), l2_alu_a, a);
            chk($sformatf("%s_hold_b_%0d", nm, k), l2_alu_b, b);
            chk($sformatf("%s_hold_op_%0d", nm, k), l2_alu_op, op);
            chk($sformatf("%s_early_valid_%0d", nm, k), l2_rsp_valid, 0);
            tick();
        end
        chk({nm, "_rsp_valid"}, l2_rsp_valid, 1);
        chk({nm, "_rsp_out"}, l2_rsp_out, exp_out);
        chk({nm, "_rsp_tag"}, l2_rsp_tag, tg);
        chk({nm, "_hold_a_end"}, l2_alu_a, a);
        tick();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [31:0] out;
        logic        zero;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, ok1, ok2, ok4, acc4;
        int acc1, acc2, n_acc;
        rsp_entry_t e;

        vt[0] = '{a: 32'd1,          b: 32'd2,          op: ALU_ADD, tag: 4'd3,  out: 32'd3,          zero: 1'b0};
        vt[1] = '{a: 32'd11,         b: 32'd20,         op: ALU_ADD, tag: 4'd1,  out: 32'd31,         zero: 1'b0};
        vt[2] = '{a: 32'd5,          b: 32'd5,          op: ALU_SUB, tag: 4'd2,  out: 32'd0,          zero: 1'b1};
        vt[3] = '{a: 32'h0000_00F0,  b: 32'h0000_003C,  op: ALU_AND, tag: 4'd4,  out: 32'h0000_0030,  zero: 1'b0};
        vt[4] = '{a: 32'h0000_00F0,  b: 32'h0000_000F,  op: ALU_OR,  tag: 4'd5,  out: 32'h0000_00FF,  zero: 1'b0};
        vt[5] = '{a: 32'd0,          b: 32'd0,          op: ALU_AND, tag: 4'd6,  out: 32'd0,          zero: 1'b1};
        vt[6] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          op: ALU_ADD, tag: 4'd14, out: 32'd0,          zero: 1'b1};
        vt[7] = '{a: 32'd0,          b: 32'd1,          op: ALU_SUB, tag: 4'd15, out: 32'hFFFF_FFFF,  zero: 1'b0};

        Rst_n = 1'b0; Cmd_valid = 1'b0; l2_valid = 1'b0; Rsp_ready = 1'b1; l2_rsp_ready = 1'b1;
        zero_bad = 1'b0; Cmd_A = '0; Cmd_B = '0; Cmd_Op = '0; Cmd_tag = '0;
        #3;
        chk("rst_cmd_ready", Cmd_ready, 0);
        chk("rst_rsp_valid", Rsp_valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_alu_a", Alu_A, 0);
        chk("rst_alu_b", Alu_B, 0);
        chk("rst_alu_op", Alu_Op, 0);
        chk("rst_rsp_out", Rsp_Out, 0);
        chk("rst_rsp_zero", Rsp_Zero, 0);
        chk("rst_rsp_tag", Rsp_tag, 0);
`ifdef ALU_CMD_CHECK_EN
        chk("rst_err_zero", Err_zero, 0);
        chk("rst_rsp_cnt", Rsp_cnt, 0);
`endif
        tick(); tick();
        Rst_n = 1'b1;
        tick();

        // Table: exact zero-latency timing for each vector.
        for (int i = 0; i < 8; i++) begin
            Cmd_A = vt[i].a; Cmd_B = vt[i].b; Cmd_Op = vt[i].op; Cmd_tag = vt[i].tag;
            Cmd_valid = 1'b1;
            chk($sformatf("v%0d_ready_idle", i), Cmd_ready, 1);
            tick();
            Cmd_valid = 1'b0;
            chk($sformatf("v%0d_alu_a", i), Alu_A, vt[i].a);
            chk($sformatf("v%0d_alu_b", i), Alu_B, vt[i].b);
            chk($sformatf("v%0d_alu_op", i), Alu_Op, vt[i].op);
            chk($sformatf("v%0d_ready_t", i), Cmd_ready, 0);
            chk($sformatf("v%0d_valid_t", i), Rsp_valid, 0);
            tick();
            chk($sformatf("v%0d_ready_t1", i), Cmd_ready, 0);
            chk($sformatf("v%0d_valid_t1", i), Rsp_valid, 0);
            tick();
            chk($sformatf("v%0d_valid_t2", i), Rsp_valid, 1);
            chk($sformatf("v%0d_out", i), Rsp_Out, vt[i].out);
            chk($sformatf("v%0d_zero", i), Rsp_Zero, vt[i].zero);
            chk($sformatf("v%0d_tag", i), Rsp_tag, vt[i].tag);
            tick();
            chk($sformatf("v%0d_popped", i), Rsp_valid, 0);
        end

        // Back-to-back commands: ordering and minimum spacing.
        rq.delete();
        send(1'b0, 32'd11, 32'd20, ALU_ADD, 4'd5, 10, ok1);
        acc1 = cyc;
        send(1'b0, 32'd5, 32'd5, ALU_SUB, 4'd6, 10, ok2);
        acc2 = cyc;
        chk("b2b_accept1", ok1, 1);
        chk("b2b_accept2", ok2, 1);
        chk("b2b_spacing_ge3", (acc2 - acc1) >= 3, 1);
        repeat (5) tick();
        chk("b2b_count", rq.size(), 2);
        e = (rq.size() > 0) ? rq[0] : '1;
        chk("b2b_r0_out", e.out, 31);
        chk("b2b_r0_zero", e.zero, 0);
        chk("b2b_r0_tag", e.tag, 5);
        e = (rq.size() > 1) ? rq[1] : '1;
        chk("b2b_r1_out", e.out, 0);
        chk("b2b_r1_zero", e.zero, 1);
        chk("b2b_r1_tag", e.tag, 6);

        // Backpressure: FIFO fills at 4, fifth command waits.
        rq.delete();
        Rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'(i + 10), 32'(i), ALU_ADD, 4'(i), 10, ok);
            if (ok) n_acc++;
        end
        send(1'b0, 32'd14, 32'd4, ALU_ADD, 4'd4, 20, ok4);
        chk("bp_accepted", n_acc, 4);
        chk("bp_tag4_blocked", ok4, 0);
        chk("bp_cmd_ready", Cmd_ready, 0);
        chk("bp_busy", Busy, 1);
        chk("bp_rsp_valid", Rsp_valid, 1);
        chk("bp_head_tag", Rsp_tag, 0);
        chk("bp_head_out", Rsp_Out, 10);
        repeat (3) tick();
        chk("bp_stall_tag", Rsp_tag, 0);
        chk("bp_stall_out", Rsp_Out, 10);
        chk("bp_stall_valid", Rsp_valid, 1);
        Rsp_ready = 1'b1;
        acc4 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (Cmd_ready) begin
                tick();
                Cmd_valid = 1'b0;
                acc4 = 1'b1;
                break;
            end
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            if (rq.size() >= 5) break;
            tick();
        end
        chk("bp_tag4_accepted", acc4, 1);
        chk("bp_pop_count", rq.size(), 5);
        for (int j = 0; j < 5; j++) begin
            e = (rq.size() > j) ? rq[j] : '1;
            chk($sformatf("bp_pop%0d_tag", j), e.tag, j);
            chk($sformatf("bp_pop%0d_out", j), e.out, 2 * j + 10);
        end

        // ALU_LAT=2 latency and operand hold.
        l2_run(32'd1, 32'd2, ALU_ADD, 4'd9, 32'd3, "lat2");

        // Async reset during WAIT with two results queued.
        l2_rsp_ready = 1'b0;
        send(1'b1, 32'd2, 32'd3, ALU_ADD, 4'd1, 10, ok);
        chk("rst_mid_acc1", ok, 1);
        send(1'b1, 32'd4, 32'd4, ALU_SUB, 4'd2, 10, ok);
        chk("rst_mid_acc2", ok, 1);
        send(1'b1, 32'd7, 32'd1, ALU_ADD, 4'd3, 10, ok);
        chk("rst_mid_acc3", ok, 1);
        tick();
        chk("rst_mid_busy_pre", l2_busy, 1);
        chk("rst_mid_valid_pre", l2_rsp_valid, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", l2_rsp_valid, 0);
        chk("rst_mid_cmd_ready", l2_cmd_ready, 0);
        chk("rst_mid_busy", l2_busy, 0);
        chk("rst_mid_alu_a", l2_alu_a, 0);
        chk("rst_mid_alu_b", l2_alu_b, 0);
        chk("rst_mid_alu_op", l2_alu_op, 0);
        chk("rst_mid_rsp_out", l2_rsp_out, 0);
        chk("rst_mid_rsp_tag", l2_rsp_tag, 0);
        chk("rst_mid_dut0_ready", Cmd_ready, 0);
        tick(); tick();
        Rst_n = 1'b1;
        tick();
        chk("rst_rel_valid", l2_rsp_valid, 0);
        chk("rst_rel_busy", l2_busy, 0);
        l2_rsp_ready = 1'b1;
        l2_run(32'd20, 32'd22, ALU_ADD, 4'd7, 32'd42, "rst_after");
        chk("rst_after_drained", l2_rsp_valid, 0);

`ifdef ALU_CMD_CHECK_EN
        chk("chk_err_init", Err_zero, 0);
        chk("chk_cnt_init", Rsp_cnt, 0);
        zero_bad = 1'b1;
        send(1'b0, 32'd3, 32'd4, ALU_ADD, 4'd9, 10, ok);
        tick(); tick();
        chk("chk_bad_out", Rsp_Out, 7);
        chk("chk_bad_zero", Rsp_Zero, 1);
        chk("chk_err_set", Err_zero, 1);
        zero_bad = 1'b0;
        tick();
        chk("chk_cnt_1", Rsp_cnt, 1);
        send(1'b0, 32'd5, 32'd5, ALU_SUB, 4'd10, 10, ok);
        repeat (3) tick();
        chk("chk_err_sticky", Err_zero, 1);
        chk("chk_cnt_2", Rsp_cnt, 2);
        Rst_n = 1'b0;
        #1;
        chk("chk_err_rst", Err_zero, 0);
        chk("chk_cnt_rst", Rsp_cnt, 0);
        tick();
        Rst_n = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
